burst_ram_arbiter: RTL and testbench
====================================

Name: burst_ram_arbiter

Overview:
Two-port arbiter that shares one BurstRAM between two burst clients, e.g. instruction cache (c0) and data cache (c1). It grants whole bursts round-robin and locks the grant until the burst completes: BURST_COUNT write beats driven, or BURST_COUNT read beats returned. It sits between the caches' br_* ports and the BurstRAM instance, and is transparent to a client when the other client is idle.

Parameters:
ADDR_BITWIDTH, 10, BurstRAM address width (64-bit word addressing)
BURST_COUNT, 4, 64-bit beats per burst (≥2)
DATA_BITWIDTH, 64, BurstRAM data width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
c0_cmd, c1_cmd  in  1  0: read, 1: write
c0_cmd_en, c1_cmd_en  in  1  request; held with cmd/addr stable until ack
c0_addr, c1_addr  in  ADDR_BITWIDTH  burst start address
c0_wr_data, c1_wr_data  in  DATA_BITWIDTH  write beat data
c0_data_mask, c1_data_mask  in  DATA_BITWIDTH/8  forwarded unchanged
c0_ack, c1_ack  out  1  one-cycle pulse: request issued to RAM this cycle
c0_rd_data, c1_rd_data  out  DATA_BITWIDTH  read beat data (shared bus)
c0_rd_data_valid, c1_rd_data_valid  out  1  read beat valid for that client
br_cmd  out  1  to BurstRAM
br_cmd_en  out  1  to BurstRAM
br_addr  out  ADDR_BITWIDTH  to BurstRAM
br_wr_data  out  DATA_BITWIDTH  to BurstRAM
br_data_mask  out  DATA_BITWIDTH/8  to BurstRAM
br_rd_data  in  DATA_BITWIDTH  from BurstRAM
br_rd_data_valid  in  1  from BurstRAM
br_busy  in  1  BurstRAM not ready (init or busy)

Behaviour:
- States: IDLE, ISSUE, WRITE, READ. Registers: state, grant (0/1), last (client granted last), beat counter of width clog2(BURST_COUNT)+1.
- Reset (async, rst_n=0): state=IDLE, grant=0, last=1 (c0 wins the first tie), counter=0. All outputs are 0: br_cmd_en, br_cmd, acks, rd_data_valids.
- IDLE: if br_busy=0 and any cN_cmd_en=1, select the winner:
  - a single requester wins;
  - on a tie, the client != last wins.
  - Register grant, go to ISSUE.
  - If br_busy=1, stay in IDLE; requests wait.
- ISSUE (exactly 1 cycle):
  - br_cmd_en=1; br_cmd, br_addr, br_wr_data, br_data_mask muxed from the granted client.
  - c<grant>_ack=1; last<=grant.
  - Next state: WRITE if cmd=1 (counter<=1), READ if cmd=0 (counter<=0).
- WRITE: br_wr_data and br_data_mask are muxed from the granted client. Beat 0 is the ISSUE cycle; beats 1..BURST_COUNT-1 are the following cycles. When counter reaches BURST_COUNT-1, return to IDLE on the next edge. The write occupies BURST_COUNT cycles in total.
- READ:
  - c<grant>_rd_data_valid = br_rd_data_valid; the other client's valid = 0.
  - Counter increments per valid beat; after beat BURST_COUNT-1, go to IDLE.
  - No timeout.
- rd_data: c0_rd_data = c1_rd_data = br_rd_data, combinational pass-through, zero latency.
- br_* outputs outside ISSUE/WRITE: br_cmd_en=0. Other br_* fields hold the granted client's values; they are don't-care to BurstRAM.
- Latency: request sampled in IDLE at edge N → ack and br_cmd_en in cycle N+1. Minimum gap between consecutive bursts is 1 IDLE cycle.
- Starvation: with both clients requesting continuously, grants strictly alternate c0, c1, c0, …
- Requests during a busy burst are not acked; the client keeps cmd_en high.
- A client must not deassert cmd_en before ack. If it does while still in IDLE, the arbiter issues no command.
- br_rd_data_valid while in IDLE/ISSUE/WRITE (stray, e.g. after reset mid-read) is dropped: no cN_rd_data_valid.
- Reset mid-burst: immediate return to IDLE. The in-flight RAM transaction is abandoned and its remaining beats are dropped per the rule above.
- br_busy rising during a burst is ignored until the next IDLE.

Test Plan:
- Single read: c0 reads addr 0x010 after RAM is preloaded with words 0x10..0x13. Required: c0_ack 1 cycle after request; c0_rd_data_valid asserts 4 times with data 0x10,0x11,0x12,0x13; c1_rd_data_valid stays 0; state returns to IDLE.
- Single write then read-back: c1 writes 4 beats 0xA0..0xA3 to addr 0x020, then reads addr 0x020. Required: br_cmd_en high for exactly 1 cycle per burst; read returns 0xA0..0xA3 on c1 only.
- Simultaneous requests from reset: c0 and c1 both assert reads in the same cycle, held. Required: c0 acked first; c1 acked only after c0's 4th valid beat plus 1 IDLE cycle; c1 data is correct.
- Continuous contention: both clients issue 6 back-to-back write bursts each. Required: ack order c0,c1,c0,c1,…; every RAM word matches the writer's data.
- br_busy gating: request held while br_busy=1 for 20 cycles. Required: no ack and no br_cmd_en until the first cycle after br_busy falls, then ack on the next cycle.
- Reset mid-read: assert rst_n=0 after the 2nd valid beat, release 1 cycle later. Required: all outputs 0 during reset; remaining beats not forwarded; a subsequent c1 read completes correctly.

Source files
------------

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one BurstRAM between two burst clients.
// A grant is held for a whole burst: BURST_COUNT write beats driven or BURST_COUNT read beats returned.
module burst_ram_arbiter #(
    parameter int ADDR_BITWIDTH = 10,
    parameter int BURST_COUNT   = 4,
    parameter int DATA_BITWIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       c0_cmd,
    input  logic                       c0_cmd_en,
    input  logic [ADDR_BITWIDTH-1:0]   c0_addr,
    input  logic [DATA_BITWIDTH-1:0]   c0_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0] c0_data_mask,
    output logic                       c0_ack,
    output logic [DATA_BITWIDTH-1:0]   c0_rd_data,
    output logic                       c0_rd_data_valid,
    input  logic                       c1_cmd,
    input  logic                       c1_cmd_en,
    input  logic [ADDR_BITWIDTH-1:0]   c1_addr,
    input  logic [DATA_BITWIDTH-1:0]   c1_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0] c1_data_mask,
    output logic                       c1_ack,
    output logic [DATA_BITWIDTH-1:0]   c1_rd_data,
    output logic                       c1_rd_data_valid,
    output logic                       br_cmd,
    output logic                       br_cmd_en,
    output logic [ADDR_BITWIDTH-1:0]   br_addr,
    output logic [DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                       br_rd_data_valid,
    input  logic                       br_busy
);

    localparam int CNT_W = $clog2(BURST_COUNT) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE, READ} state_t;

    state_t           state, state_next;
    logic             grant, grant_next;
    logic             last, last_next;
    logic [CNT_W-1:0] count, count_next;
    logic             sel_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            count <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            last  <= last_next;
            count <= count_next;
        end
    end

    assign sel_cmd = grant ? c1_cmd : c0_cmd;

    // A write counts the ISSUE cycle as beat 0, so WRITE starts at beat 1.
    always_comb begin
        state_next       = state;
        grant_next       = grant;
        last_next        = last;
        count_next       = count;
        br_cmd_en        = 1'b0;
        c0_ack           = 1'b0;
        c1_ack           = 1'b0;
        c0_rd_data_valid = 1'b0;
        c1_rd_data_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!br_busy && (c0_cmd_en || c1_cmd_en)) begin
                    if (c0_cmd_en && c1_cmd_en)
                        grant_next = ~last;
                    else
                        grant_next = c1_cmd_en;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                br_cmd_en = 1'b1;
                c0_ack    = ~grant;
                c1_ack    = grant;
                last_next = grant;
                if (sel_cmd) begin
                    state_next = WRITE;
                    count_next = CNT_W'(1);
                end else begin
                    state_next = READ;
                    count_next = '0;
                end
            end
            WRITE: begin
                if (count == LAST_BEAT)
                    state_next = IDLE;
                else
                    count_next = count + 1'b1;
            end
            READ: begin
                c0_rd_data_valid = br_rd_data_valid & ~grant;
                c1_rd_data_valid = br_rd_data_valid & grant;
                if (br_rd_data_valid) begin
                    if (count == LAST_BEAT)
                        state_next = IDLE;
                    else
                        count_next = count + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // br_cmd is forced low in IDLE so it reads 0 while reset is held.
    assign br_cmd       = (state != IDLE) && sel_cmd;
    assign br_addr      = grant ? c1_addr : c0_addr;
    assign br_wr_data   = grant ? c1_wr_data : c0_wr_data;
    assign br_data_mask = grant ? c1_data_mask : c0_data_mask;
    assign c0_rd_data   = br_rd_data;
    assign c1_rd_data   = br_rd_data;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small behavioural BurstRAM and two burst clients.
module tb_burst_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_cmd, c0_cmd_en, c1_cmd, c1_cmd_en;
    logic [9:0]  c0_addr, c1_addr;
    logic [63:0] c0_wr_data, c1_wr_data;
    logic [7:0]  c0_data_mask, c1_data_mask;
    logic        c0_ack, c1_ack, c0_rd_data_valid, c1_rd_data_valid;
    logic [63:0] c0_rd_data, c1_rd_data;
    logic        br_cmd, br_cmd_en;
    logic [9:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data = '0;
    logic        br_rd_data_valid = 1'b0;
    logic        br_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    burst_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c0_cmd(c0_cmd), .c0_cmd_en(c0_cmd_en), .c0_addr(c0_addr), .c0_wr_data(c0_wr_data),
        .c0_data_mask(c0_data_mask), .c0_ack(c0_ack), .c0_rd_data(c0_rd_data),
        .c0_rd_data_valid(c0_rd_data_valid),
        .c1_cmd(c1_cmd), .c1_cmd_en(c1_cmd_en), .c1_addr(c1_addr), .c1_wr_data(c1_wr_data),
        .c1_data_mask(c1_data_mask), .c1_ack(c1_ack), .c1_rd_data(c1_rd_data),
        .c1_rd_data_valid(c1_rd_data_valid),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
        .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BurstRAM model: 4-beat bursts, read beats start two cycles after the command; not reset by rst_n.
    logic [63:0] mem [0:1023];
    logic        preloaded = 1'b0;
    logic [9:0]  wr_ptr = '0, rd_ptr = '0;
    int          wr_left = 0, rd_left = 0, rd_wait = 0;

    always @(posedge clk) begin
        br_rd_data_valid <= 1'b0;
        if (!preloaded) begin
            for (int i = 0; i < 4; i++) mem[10'(16 + i)] <= 64'(16 + i);
            preloaded <= 1'b1;
        end
        if (br_cmd_en && br_cmd) begin
            mem[br_addr] <= br_wr_data;
            wr_ptr       <= br_addr + 10'd1;
            wr_left      <= 3;
        end else if (wr_left > 0) begin
            mem[wr_ptr] <= br_wr_data;
            wr_ptr      <= wr_ptr + 10'd1;
            wr_left     <= wr_left - 1;
        end
        if (br_cmd_en && !br_cmd) begin
            rd_ptr  <= br_addr;
            rd_left <= 4;
            rd_wait <= 1;
        end else if (rd_left > 0) begin
            if (rd_wait > 0) begin
                rd_wait <= rd_wait - 1;
            end else begin
                br_rd_data_valid <= 1'b1;
                br_rd_data       <= mem[rd_ptr];
                rd_ptr           <= rd_ptr + 10'd1;
                rd_left          <= rd_left - 1;
            end
        end
    end

    // Client write-data sequencers: beat k of a burst carries base + k.
    logic [63:0] c0_req_base = '0, c1_req_base = '0, c0_cur = '0, c1_cur = '0;
    logic [1:0]  c0_beat = 2'd0, c1_beat = 2'd0;

    always @(posedge clk) begin
        if (c0_ack) begin
            c0_beat <= 2'd1;
            c0_cur  <= c0_req_base;
        end else if (c0_beat != 2'd0 && c0_beat != 2'd3) begin
            c0_beat <= c0_beat + 2'd1;
        end
        if (c1_ack) begin
            c1_beat <= 2'd1;
            c1_cur  <= c1_req_base;
        end else if (c1_beat != 2'd0 && c1_beat != 2'd3) begin
            c1_beat <= c1_beat + 2'd1;
        end
    end

    assign c0_wr_data = c0_ack ? c0_req_base : c0_cur + 64'(c0_beat);
    assign c1_wr_data = c1_ack ? c1_req_base : c1_cur + 64'(c1_beat);

    // Observation log, sampled on the falling edge.
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    int          ack_ids [$];
    int          ack_cyc [$];
    int          cmd_en_cnt = 0;
    int          beat0_cyc = 0;
    logic [7:0]  c1_mask_seen = '0;
    logic [9:0]  c1_addr_seen = '0;

    always @(negedge clk) begin
        if (c0_rd_data_valid) begin
            q0.push_back(c0_rd_data);
            beat0_cyc = cyc;
        end
        if (c1_rd_data_valid) q1.push_back(c1_rd_data);
        if (br_cmd_en) cmd_en_cnt = cmd_en_cnt + 1;
        if (c0_ack) begin
            ack_ids.push_back(0);
            ack_cyc.push_back(cyc);
        end
        if (c1_ack) begin
            ack_ids.push_back(1);
            ack_cyc.push_back(cyc);
            c1_mask_seen = br_data_mask;
            c1_addr_seen = br_addr;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Raise a request, wait (bounded) for its ack, hold through ISSUE, then drop cmd_en.
    task automatic applyStimulus(input int id, input logic cmd, input logic [9:0] addr,
                                 input logic [63:0] base, output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        if (id == 0) begin
            c0_cmd = cmd; c0_addr = addr; c0_req_base = base; c0_cmd_en = 1'b1;
        end else begin
            c1_cmd = cmd; c1_addr = addr; c1_req_base = base; c1_cmd_en = 1'b1;
        end
        while (!got && waited < 200) begin
            @(negedge clk);
            waited++;
            got = (id == 0) ? c0_ack : c1_ack;
        end
        checkOutput("ack_seen", 64'(got), 64'd1);
        @(negedge clk);
        if (id == 0) c0_cmd_en = 1'b0;
        else         c1_cmd_en = 1'b0;
    endtask

    function automatic logic [63:0] outBundle();
        return {58'd0, br_cmd_en, br_cmd, c0_ack, c1_ack, c0_rd_data_valid, c1_rd_data_valid};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int w0, w1, q0s, q1s, ack_s, cmd_s, fall_cyc;
        rst_n = 1'b0;
        c0_cmd = 1'b1; c1_cmd = 1'b1; c0_cmd_en = 1'b0; c1_cmd_en = 1'b0;
        c0_addr = '0; c1_addr = '0; c0_data_mask = 8'h0F; c1_data_mask = 8'hF0;
        br_busy = 1'b0;
        #23;
        checkOutput("reset_outputs", outBundle(), 64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] single read c0 @0x010");
        q0s = q0.size(); q1s = q1.size();
        applyStimulus(0, 1'b0, 10'h010, 64'd0, w0);
        checkOutput("rd_ack_latency", 64'(w0), 64'd1);
        tick(10);
        checkOutput("rd_beats", 64'(q0.size() - q0s), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("rd_data", (q0.size() > q0s + i) ? q0[q0s + i] : 64'hDEAD, 64'h10 + 64'(i));
        checkOutput("rd_no_c1_valid", 64'(q1.size() - q1s), 64'd0);

        $display("[TB] c1 write 0xA0..0xA3 @0x020 then read back");
        cmd_s = cmd_en_cnt; q0s = q0.size(); q1s = q1.size();
        applyStimulus(1, 1'b1, 10'h020, 64'hA0, w1);
        checkOutput("wr_ack_latency", 64'(w1), 64'd1);
        checkOutput("wr_mask_fwd", 64'(c1_mask_seen), 64'hF0);
        checkOutput("wr_addr_fwd", 64'(c1_addr_seen), 64'h020);
        tick(4);
        for (int i = 0; i < 4; i++)
            checkOutput("wr_mem", mem[10'(32 + i)], 64'hA0 + 64'(i));
        applyStimulus(1, 1'b0, 10'h020, 64'd0, w1);
        checkOutput("rb_ack_latency", 64'(w1), 64'd1);
        tick(10);
        checkOutput("rb_beats", 64'(q1.size() - q1s), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("rb_data", (q1.size() > q1s + i) ? q1[q1s + i] : 64'hDEAD, 64'hA0 + 64'(i));
        checkOutput("rb_no_c0_valid", 64'(q0.size() - q0s), 64'd0);
        checkOutput("cmd_en_pulses", 64'(cmd_en_cnt - cmd_s), 64'd2);

        $display("[TB] simultaneous reads from reset");
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        q1s = q1.size(); ack_s = ack_ids.size();
        fork
            applyStimulus(0, 1'b0, 10'h010, 64'd0, w0);
            applyStimulus(1, 1'b0, 10'h020, 64'd0, w1);
        join
        tick(10);
        checkOutput("tie_c0_latency", 64'(w0), 64'd1);
        checkOutput("tie_ack_count", 64'(ack_ids.size() - ack_s), 64'd2);
        if (ack_ids.size() >= ack_s + 2) begin
            checkOutput("tie_first", 64'(ack_ids[ack_s]), 64'd0);
            checkOutput("tie_second", 64'(ack_ids[ack_s + 1]), 64'd1);
            checkOutput("tie_c1_gap", 64'(ack_cyc[ack_s + 1] - beat0_cyc), 64'd2);
        end
        for (int i = 0; i < 4; i++)
            checkOutput("tie_c1_data", (q1.size() > q1s + i) ? q1[q1s + i] : 64'hDEAD, 64'hA0 + 64'(i));

        $display("[TB] continuous write contention");
        ack_s = ack_ids.size();
        fork
            for (int k = 0; k < 6; k++) applyStimulus(0, 1'b1, 10'(256 + 4 * k), 64'hC00 + 64'(4 * k), w0);
            for (int k = 0; k < 6; k++) applyStimulus(1, 1'b1, 10'(512 + 4 * k), 64'hD00 + 64'(4 * k), w1);
        join
        tick(8);
        checkOutput("rr_ack_count", 64'(ack_ids.size() - ack_s), 64'd12);
        for (int i = 0; i < 12; i++)
            checkOutput("rr_order", (ack_ids.size() > ack_s + i) ? 64'(ack_ids[ack_s + i]) : 64'hF, 64'(i % 2));
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < 4; b++) begin
                checkOutput("rr_mem_c0", mem[10'(256 + 4 * k + b)], 64'hC00 + 64'(4 * k + b));
                checkOutput("rr_mem_c1", mem[10'(512 + 4 * k + b)], 64'hD00 + 64'(4 * k + b));
            end
        end

        $display("[TB] br_busy gating");
        br_busy = 1'b1;
        tick(1);
        ack_s = ack_ids.size(); cmd_s = cmd_en_cnt; fall_cyc = 0;
        fork
            applyStimulus(0, 1'b0, 10'h010, 64'd0, w0);
            begin
                tick(20);
                checkOutput("busy_no_ack", 64'(ack_ids.size() - ack_s), 64'd0);
                checkOutput("busy_no_cmd_en", 64'(cmd_en_cnt - cmd_s), 64'd0);
                br_busy = 1'b0;
                fall_cyc = cyc;
            end
        join
        tick(10);
        checkOutput("busy_ack_count", 64'(ack_ids.size() - ack_s), 64'd1);
        if (ack_cyc.size() > ack_s)
            checkOutput("busy_ack_cycle", 64'(ack_cyc[ack_s] - fall_cyc), 64'd1);

        $display("[TB] reset mid-read");
        q0s = q0.size(); q1s = q1.size();
        applyStimulus(0, 1'b0, 10'h010, 64'd0, w0);
        for (int i = 0; i < 50 && q0.size() < q0s + 2; i++) tick(1);
        c0_cmd = 1'b1; c1_cmd = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_outputs_a", outBundle(), 64'd0);
        tick(1);
        checkOutput("midrst_outputs_b", outBundle(), 64'd0);
        rst_n = 1'b1;
        tick(6);
        checkOutput("midrst_dropped", 64'(q0.size() - q0s), 64'd2);
        applyStimulus(1, 1'b0, 10'h020, 64'd0, w1);
        checkOutput("midrst_c1_latency", 64'(w1), 64'd1);
        tick(10);
        for (int i = 0; i < 4; i++)
            checkOutput("midrst_c1_data", (q1.size() > q1s + i) ? q1[q1s + i] : 64'hDEAD, 64'hA0 + 64'(i));
        checkOutput("midrst_c0_quiet", 64'(q0.size() - q0s), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
